// File: rtl/led_pkg.sv
// Shared definitions for the LED bank.
//   led_mode_e  : per-channel 2-bit mode encoding carried on led_bank.mode
//   cnt_width() : bits needed to hold a value 0..max_val (never less than 1)
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_FLASH = 2'b11
  } led_mode_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser and debouncer.
//   clk   : sole clock, rising edge
//   rst   : synchronous active-high reset
//   sw    : raw asynchronous switch, active-low (0 = pressed)
//   level : debounced pressed state (1 = pressed), registered
//   press : one-cycle pulse, high in the first cycle level reads 1
module sw_debounce #(
  parameter int DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic press
);

  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  // Synchroniser resets to 1 so a reset never looks like a press.
  logic          sync1;
  logic          sync2;
  logic          raw;
  logic [DW-1:0] cnt;

  assign raw = ~sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      press <= 1'b0;
      // Count consecutive cycles of disagreement; any agreeing cycle restarts.
      if (raw != level) begin
        if (cnt == DB_LAST) begin
          level <= raw;
          cnt   <= '0;
          press <= raw;   // only a 0->1 change produces a pulse
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_bank.sv
// Multi-channel LED driver with blink, one-shot flash and a debounced switch
// override.
//   clk, rst   : sole clock; synchronous active-high reset
//   sw         : raw active-low switch (asynchronous)
//   mode       : 2 bits per channel, channel i at [2i+1:2i] (led_mode_e)
//   pulse_req  : per-channel flash trigger, level sampled every cycle
//   led        : registered LED drives, 1 = lit
//   sw_level   : debounced pressed state
//   sw_press   : one-cycle pulse on debounced press
//   heartbeat  : toggles every cycle
module led_bank
  import led_pkg::*;
#(
  parameter int NUM_LEDS    = 3,
  parameter int TICK_DIV    = 62500000,
  parameter int DB_CYCLES   = 65536,
  parameter int PULSE_TICKS = 4,
  parameter int SW_CH       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw,
  input  logic [2*NUM_LEDS-1:0] mode,
  input  logic [NUM_LEDS-1:0]   pulse_req,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  sw_level,
  output logic                  sw_press,
  output logic                  heartbeat
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = cnt_width(PULSE_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(PULSE_TICKS);

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            phase;
  logic            phase_n;
  logic [FW-1:0]   flash_q [NUM_LEDS];
  logic [FW-1:0]   flash_n [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_d;

  sw_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_sw_debounce (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .level(sw_level),
    .press(sw_press)
  );

  // Tick generator: one-cycle tick on the last count of each period.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign phase_n = phase ^ tick;

  // Flash counters: reload beats the tick decrement; non-FLASH channels idle at 0.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      flash_n[i] = flash_q[i];
      if (led_mode_e'(mode[2*i +: 2]) != MODE_FLASH) begin
        flash_n[i] = '0;
      end else if (pulse_req[i]) begin
        flash_n[i] = FLASH_LOAD;
      end else if (tick && (flash_q[i] != '0)) begin
        flash_n[i] = flash_q[i] - 1'b1;
      end
    end
  end

  // LED decode uses the next-state phase and counters so the registered led
  // changes on the same edge as the state it reflects.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (led_mode_e'(mode[2*i +: 2]))
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = ((i % 2) == 0) ? phase_n : ~phase_n;
        MODE_FLASH: led_d[i] = (flash_n[i] != '0);
        default:    led_d[i] = 1'b0;
      endcase
    end
    if (sw_level) led_d[SW_CH] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 1'b0;
      led       <= '0;
      heartbeat <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) flash_q[i] <= '0;
    end else begin
      phase     <= phase_n;
      led       <= led_d;
      heartbeat <= ~heartbeat;
      for (int i = 0; i < NUM_LEDS; i++) flash_q[i] <= flash_n[i];
    end
  end

endmodule
